// File: rtl/uart_link_pkg.sv
// Constants and state encoding shared by both ends of the idle-gap serial link.
// Default timing: 65 MHz clock, 9600 baud, 162-bit packets.
package uart_link_pkg;

  localparam int CLK_PER_SAMP   = 423;
  localparam int SAMP_PER_BIT   = 16;
  localparam int CLK_PER_BIT    = CLK_PER_SAMP * SAMP_PER_BIT;
  localparam int PKT_LEN        = 162;

  // The transmitter gap must beat the receiver's idle detector.
  localparam int RX_IDLE_CLKS   = 130_000;
  localparam int IDLE_CLKS      = 131_072;
  localparam int RST_GUARD_CLKS = 1_300_000;
  localparam int GUARD_W        = 21;

  typedef enum logic [3:0] {
    TX_IDLE  = 4'b0001,
    TX_ARMED = 4'b0010,
    TX_START = 4'b0100,
    TX_DATA  = 4'b1000
  } tx_state_t;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: one-cycle tick every CLK_PER_BIT clocks, restartable via clr_i.
module bit_tick_gen #(
  parameter int CLK_PER_BIT = uart_link_pkg::CLK_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uat_fsm.sv
// Serial packet transmitter: idle-high guard gap, one low start bit, then PKT_LEN
// data bits LSB first. Line-side outputs are registered one cycle behind the state.
module uat_fsm #(
  parameter int CLK_PER_BIT    = uart_link_pkg::CLK_PER_BIT,
  parameter int PKT_LEN        = uart_link_pkg::PKT_LEN,
  parameter int IDLE_CLKS      = uart_link_pkg::IDLE_CLKS,
  parameter int RST_GUARD_CLKS = uart_link_pkg::RST_GUARD_CLKS
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [PKT_LEN-1:0] data_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic               tx_out,
  output logic               busy_out,
  output logic               done_out
);

  import uart_link_pkg::*;

  localparam int BIT_W = $clog2(PKT_LEN + 1);
  localparam logic [GUARD_W-1:0] IDLE_LIM = GUARD_W'(IDLE_CLKS);
  localparam logic [GUARD_W-1:0] RST_LIM  = GUARD_W'(RST_GUARD_CLKS);
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(PKT_LEN - 1);

  tx_state_t           state_q, state_d;
  logic [PKT_LEN-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GUARD_W-1:0]  guard_q, guard_d;
  logic [GUARD_W-1:0]  lim_q, lim_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                fin_q, fin_d;
  logic                done_q, done_d;

  logic tick;
  logic tick_clr;
  logic accept;
  logic guard_full;
  logic last_bit;

  bit_tick_gen #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_tick (
    .clk_i (clk_in),
    .rst_ni(rst_in),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  assign accept     = valid_in && ready_q;
  assign guard_full = (guard_q == lim_q);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    guard_d   = guard_q;
    lim_d     = lim_q;
    tick_clr  = 1'b0;
    last_bit  = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (accept) begin
          shift_d = data_in;
          state_d = TX_ARMED;
        end
      end
      TX_ARMED: begin
        if (guard_full) begin
          state_d  = TX_START;
          tick_clr = 1'b1;
        end
      end
      TX_START: begin
        if (tick) begin
          state_d   = TX_DATA;
          bit_cnt_d = '0;
        end
      end
      TX_DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            last_bit = 1'b1;
            state_d  = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // After the first frame the gap only needs to cover the receiver's idle detector.
    if (last_bit) begin
      guard_d = '0;
      lim_d   = IDLE_LIM;
    end else if ((state_q == TX_IDLE || state_q == TX_ARMED) && !guard_full) begin
      guard_d = guard_q + 1'b1;
    end

    case (state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase

    // fin/done delay keeps done, ready and the line release in the same cycle.
    ready_d = (state_q == TX_IDLE) && !accept;
    fin_d   = last_bit;
    done_d  = fin_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      guard_q   <= '0;
      lim_q     <= RST_LIM;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      fin_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      guard_q   <= guard_d;
      lim_q     <= lim_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      fin_q     <= fin_d;
      done_q    <= done_d;
    end
  end

  assign ready_out = ready_q;
  assign busy_out  = ~ready_q;
  assign tx_out    = tx_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_uat_fsm.sv
// Directed bench for uat_fsm with shrunken timing; a frame-timeline model checks
// every cycle, and literal timing checks pin the model.
module tb_uat_fsm;

  localparam int CPB   = 4;
  localparam int PL    = 10;
  localparam int IDL   = 20;
  localparam int RG    = 70;
  localparam int FRAME = (PL + 1) * CPB;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          valid_in;
  logic [PL-1:0] data_in;
  logic          ready_out;
  logic          tx_out;
  logic          busy_out;
  logic          done_out;

  uat_fsm #(
    .CLK_PER_BIT   (CPB),
    .PKT_LEN       (PL),
    .IDLE_CLKS     (IDL),
    .RST_GUARD_CLKS(RG)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .tx_out   (tx_out),
    .busy_out (busy_out),
    .done_out (done_out)
  );

  always #5 clk_in = ~clk_in;

  int     vectors     = 0;
  int     miscompares = 0;
  longint cyc         = 0;

  // Timeline model: each frame has a start edge and ends FRAME clocks later.
  logic          m_live = 1'b0;
  logic          m_ready = 1'b1;
  logic          m_have = 1'b0;
  logic [PL-1:0] m_word = '0;
  longint        m_start = 0;
  longint        m_earliest = 0;
  longint        m_done_at = -1;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (!rst_in) begin
      m_live     <= 1'b1;
      m_ready    <= 1'b1;
      m_have     <= 1'b0;
      m_earliest <= cyc + 1 + RG + 2;
      m_done_at  <= -1;
    end else if (m_live) begin
      if (m_ready && valid_in) begin
        m_ready <= 1'b0;
        m_have  <= 1'b1;
        m_word  <= data_in;
        m_start <= (cyc + 3 > m_earliest) ? cyc + 3 : m_earliest;
      end else if (!m_ready && (cyc + 1 == m_start + FRAME)) begin
        m_ready    <= 1'b1;
        m_done_at  <= cyc + 1;
        m_earliest <= cyc + 1 + IDL + 1;
      end
    end
  end

  always @(negedge clk_in) begin
    logic   e_tx;
    longint k;
    if (m_live) begin
      e_tx = 1'b1;
      if (m_have && cyc >= m_start && cyc < m_start + FRAME) begin
        k    = (cyc - m_start) / CPB;
        e_tx = (k == 0) ? 1'b0 : m_word[int'(k - 1)];
      end
      vectors++;
      if ({tx_out, ready_out, busy_out, done_out} !==
          {e_tx, m_ready, !m_ready, (cyc == m_done_at)}) begin
        miscompares++;
        $display("FAIL cycle %0d tx/ready/busy/done: got %b%b%b%b expected %b%b%b%b",
                 cyc, tx_out, ready_out, busy_out, done_out,
                 e_tx, m_ready, !m_ready, (cyc == m_done_at));
      end
    end
  end

  task automatic lit(input string name, input longint got, input longint want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic wait_tx_low(input int budget, output longint at);
    int n;
    n  = 0;
    at = -1;
    while (tx_out !== 1'b0 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (tx_out === 1'b0) begin
      at = cyc;
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL wait_tx_low: no start bit within %0d cycles", budget);
    end
  endtask

  task automatic wait_done(input int budget, output longint at);
    int n;
    n  = 0;
    at = -1;
    while (done_out !== 1'b1 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (done_out === 1'b1) begin
      at = cyc;
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
  endtask

  task automatic send_one(input logic [PL-1:0] word);
    data_in  = word;
    valid_in = 1'b1;
    $display("txn: offer %h at cycle %0d", word, cyc);
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  initial begin
    longint rl;
    longint t_fall;
    longint t_done;
    longint ta;

    rst_in   = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;

    // Long idle after reset: line stays high, nothing pulses.
    repeat (100) @(negedge clk_in);
    lit("idle_tx", tx_out, 1);
    lit("idle_ready", ready_out, 1);
    lit("idle_busy", busy_out, 0);
    $display("txn: idle window done at cycle %0d", cyc);

    // First frame after reset waits out the reset guard.
    rst_in = 1'b0;
    @(negedge clk_in);
    rl     = cyc;
    rst_in = 1'b1;
    repeat (10) @(negedge clk_in);
    send_one(10'h001);
    lit("armed_busy", busy_out, 1);
    wait_tx_low(200, t_fall);
    lit("rst_guard_start", t_fall - rl, 72);
    wait_done(100, t_done);
    lit("frame_len", t_done - t_fall, 44);
    lit("done_tx_high", tx_out, 1);
    lit("done_ready", ready_out, 1);

    // Guard already saturated: start bit two cycles after the handshake.
    repeat (30) @(negedge clk_in);
    ta = cyc + 1;
    send_one(10'h2AA);
    wait_tx_low(20, t_fall);
    lit("sat_latency", t_fall - ta, 2);
    repeat (6) @(negedge clk_in);
    lit("alt_bit0", tx_out, 0);
    repeat (4) @(negedge clk_in);
    lit("alt_bit1", tx_out, 1);
    wait_done(100, t_done);

    // valid held high: B is accepted in A's done cycle, then waits the idle gap.
    repeat (30) @(negedge clk_in);
    data_in  = 10'h35C;
    valid_in = 1'b1;
    $display("txn: offer %h at cycle %0d (held)", data_in, cyc);
    @(negedge clk_in);
    lit("a_taken", ready_out, 0);
    data_in = 10'h0F3;
    $display("txn: offer %h at cycle %0d (held)", data_in, cyc);
    wait_done(200, t_done);
    lit("b_accept_in_done", ready_out, 1);
    @(negedge clk_in);
    valid_in = 1'b0;
    lit("b_taken", ready_out, 0);
    wait_tx_low(100, t_fall);
    lit("b2b_gap", t_fall - t_done, 21);
    wait_done(100, t_done);

    // Reset in the middle of data bit 5: frame dropped, reset guard applies again.
    repeat (30) @(negedge clk_in);
    send_one(10'h3C5);
    wait_tx_low(20, t_fall);
    repeat (25) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rl     = cyc;
    rst_in = 1'b1;
    lit("midrst_tx", tx_out, 1);
    lit("midrst_busy", busy_out, 0);
    send_one(10'h155);
    wait_tx_low(150, t_fall);
    lit("midrst_guard_start", t_fall - rl, 72);
    wait_done(100, t_done);

    repeat (5) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
